// File: rtl/btn_step_pkg.sv
// Shared FSM state encoding and step-direction constants for the push-button step controller.
`timescale 1ns/1ps
package btn_step_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_e;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Picks the debounced level of the button that corresponds to a direction.
    function automatic logic sel_btn(input logic dir, input logic inc_lvl, input logic dec_lvl);
        return (dir == DIR_INC) ? inc_lvl : dec_lvl;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer for one raw push-button.
`timescale 1ns/1ps
module btn_debounce
    import btn_step_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample that agrees with the stable level restarts the run of differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;

endmodule

// File: rtl/btn_step_ctrl.sv
// Push-button step controller: debounced inc/dec buttons -> fixed-width step pulses for the PWM stage.
// Optional auto-repeat while a button is held is built only when AUTO_REPEAT_EN is defined.
`timescale 1ns/1ps
module btn_step_ctrl
    import btn_step_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 1_000_000,
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000,
    parameter int unsigned PULSE_LEN    = 524_288
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_raw,
    input  logic dec_raw,
    output logic inc,
    output logic dec,
    output logic busy
);

    localparam int unsigned PLS_W = $clog2(PULSE_LEN + 1);

    logic             inc_db_s;
    logic             dec_db_s;
    logic             act_btn_s;
    logic             oth_btn_s;
    logic             step_req_s;
    state_e           state_q;
    state_e           state_d;
    logic             act_q;
    logic             act_d;
    logic [PLS_W-1:0] pls_cnt_q;
    logic [PLS_W-1:0] pls_cnt_d;
    logic             inc_q;
    logic             inc_d;
    logic             dec_q;
    logic             dec_d;
    logic             busy_q;
    logic             busy_d;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
`endif

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (inc_raw),
        .level_o (inc_db_s)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (dec_raw),
        .level_o (dec_db_s)
    );

    assign act_btn_s = sel_btn(act_q, inc_db_s, dec_db_s);
    assign oth_btn_s = sel_btn(~act_q, inc_db_s, dec_db_s);

    // Step FSM: a timer load of N-1 makes the next step land exactly N edges after the previous one.
    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        step_req_s = 1'b0;
`ifdef AUTO_REPEAT_EN
        tmr_d      = (tmr_q == {TMR_W{1'b0}}) ? {TMR_W{1'b0}} : (tmr_q - TMR_W'(1));
`endif
        case (state_q)
            IDLE: begin
                if (inc_db_s && dec_db_s) begin
                    state_d = LOCK;
                end else if (inc_db_s || dec_db_s) begin
                    step_req_s = 1'b1;
                    act_d      = inc_db_s ? DIR_INC : DIR_DEC;
                    state_d    = FIRST;
`ifdef AUTO_REPEAT_EN
                    tmr_d      = TMR_W'(REPEAT_DELAY - 1);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            FIRST: begin
                if (oth_btn_s) begin
                    state_d = LOCK;
                end else if (!act_btn_s) begin
                    state_d = IDLE;
`ifdef AUTO_REPEAT_EN
                end else if (tmr_q == {TMR_W{1'b0}}) begin
                    step_req_s = 1'b1;
                    tmr_d      = TMR_W'(REPEAT_RATE - 1);
                    state_d    = REPEAT;
`endif
                end else begin
                    state_d = FIRST;
                end
            end
`ifdef AUTO_REPEAT_EN
            REPEAT: begin
                if (oth_btn_s) begin
                    state_d = LOCK;
                end else if (!act_btn_s) begin
                    state_d = IDLE;
                end else if (tmr_q == {TMR_W{1'b0}}) begin
                    step_req_s = 1'b1;
                    tmr_d      = TMR_W'(REPEAT_RATE - 1);
                    state_d    = REPEAT;
                end else begin
                    state_d = REPEAT;
                end
            end
`endif
            LOCK: begin
                if (!inc_db_s && !dec_db_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pulse generator: requests arriving while busy are dropped, not queued.
    always_comb begin
        pls_cnt_d = pls_cnt_q;
        inc_d     = inc_q;
        dec_d     = dec_q;
        busy_d    = busy_q;
        if (step_req_s && !busy_q) begin
            busy_d    = 1'b1;
            inc_d     = (act_d == DIR_INC);
            dec_d     = (act_d == DIR_DEC);
            pls_cnt_d = PLS_W'(PULSE_LEN - 1);
        end else if (busy_q) begin
            if (pls_cnt_q == {PLS_W{1'b0}}) begin
                busy_d = 1'b0;
                inc_d  = 1'b0;
                dec_d  = 1'b0;
            end else begin
                pls_cnt_d = pls_cnt_q - PLS_W'(1);
            end
        end else begin
            pls_cnt_d = {PLS_W{1'b0}};
        end
    end

    // FSM, direction and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            act_q     <= DIR_DEC;
            pls_cnt_q <= {PLS_W{1'b0}};
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            pls_cnt_q <= pls_cnt_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            busy_q    <= busy_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    // Repeat timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= {TMR_W{1'b0}};
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

    assign inc  = inc_q;
    assign dec  = dec_q;
    assign busy = busy_q;

endmodule
